const_splitter: RTL and testbench

Decomposes a full-width constant into a minimal sequence of immediate-field chunks for the instruction builder, one chunk per handshake. The first chunk is meant for a load-immediate, and sign-extending it reproduces the upper part of the value. Each following chunk is meant for a shift-left-by-IMMEDIATE_WIDTH-then-OR step that merges it in zero-extended. The block sits between the constant source (loader/test sequencer) and the instruction emitter, and is the inverse of the immediate sign-extension path in the datapath.

---
 rtl/const_splitter_pkg.sv | 22 ++
 rtl/const_splitter_chunk_count_detect.sv | 24 ++
 rtl/const_splitter.sv | 104 ++++++++++
 tb/tb_const_splitter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/const_splitter_pkg.sv
// Shared widths for the constant splitter and a helper that selects one immediate-sized chunk
// out of the sign-extended constant.
package const_splitter_pkg;
  localparam int IMMEDIATE_WIDTH = 6;
  localparam int DATA_BUS_WIDTH  = 16;
  localparam int CHUNK_COUNT     = (DATA_BUS_WIDTH + IMMEDIATE_WIDTH - 1) / IMMEDIATE_WIDTH;
  localparam int CHUNK_IDX_WIDTH = (CHUNK_COUNT > 1) ? $clog2(CHUNK_COUNT) : 1;
  localparam int EXT_WIDTH       = CHUNK_COUNT * IMMEDIATE_WIDTH;

  // Chunk position 0 is the least significant IMMEDIATE_WIDTH bits.
  function automatic logic [IMMEDIATE_WIDTH-1:0] chunk_at(
    input logic [EXT_WIDTH-1:0]       ext,
    input logic [CHUNK_IDX_WIDTH-1:0] pos
  );
    logic [IMMEDIATE_WIDTH-1:0] c;
    c = '0;
    for (int p = 0; p < CHUNK_COUNT; p++) begin
      if (pos == CHUNK_IDX_WIDTH'(p)) c = ext[p*IMMEDIATE_WIDTH +: IMMEDIATE_WIDTH];
    end
    return c;
  endfunction
endpackage

// File: rtl/const_splitter_chunk_count_detect.sv
// Combinational: sign-extends the constant and finds the smallest chunk count that still
// reproduces it, reported as count-1.
module chunk_count_detect
  import const_splitter_pkg::*;
(
  input  logic [DATA_BUS_WIDTH-1:0]  in_value,
  output logic [EXT_WIDTH-1:0]       value_ext,
  output logic [CHUNK_IDX_WIDTH-1:0] last_idx
);
  always_comb begin
    logic [EXT_WIDTH-1:0] run;
    value_ext = EXT_WIDTH'($signed(in_value));
    // run[i] is set when every bit from the top down to i equals the sign bit.
    run = '0;
    run[EXT_WIDTH-1] = 1'b1;
    for (int i = EXT_WIDTH - 2; i >= 0; i--) begin
      run[i] = run[i+1] & (value_ext[i] == value_ext[EXT_WIDTH-1]);
    end
    last_idx = CHUNK_IDX_WIDTH'(CHUNK_COUNT - 1);
    for (int n = CHUNK_COUNT - 1; n >= 1; n--) begin
      if (run[n*IMMEDIATE_WIDTH-1]) last_idx = CHUNK_IDX_WIDTH'(n - 1);
    end
  end
endmodule

// File: rtl/const_splitter.sv
// Splits a constant into a sign-extended head chunk plus zero-extended tail chunks, one per
// handshake; first chunk valid the cycle after accept, outputs held while out_ready is low.
module const_splitter
  import const_splitter_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_BUS_WIDTH-1:0]  in_value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IMMEDIATE_WIDTH-1:0] out_chunk,
  output logic                       out_first,
  output logic                       out_last,
  output logic [CHUNK_IDX_WIDTH-1:0] out_index
);
  typedef enum logic {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [EXT_WIDTH-1:0]       ext_q, ext_d;
  logic [CHUNK_IDX_WIDTH-1:0] last_idx_q, last_idx_d;
  logic [CHUNK_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IMMEDIATE_WIDTH-1:0] chunk_q, chunk_d;
  logic                       first_q, first_d;
  logic                       last_q, last_d;

  logic [EXT_WIDTH-1:0]       in_ext;
  logic [CHUNK_IDX_WIDTH-1:0] in_last_idx;

  chunk_count_detect u_detect (
    .in_value  (in_value),
    .value_ext (in_ext),
    .last_idx  (in_last_idx)
  );

  always_comb begin
    state_d    = state_q;
    ext_d      = ext_q;
    last_idx_d = last_idx_q;
    idx_d      = idx_q;
    chunk_d    = chunk_q;
    first_d    = first_q;
    last_d     = last_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ext_d      = in_ext;
          last_idx_d = in_last_idx;
          idx_d      = '0;
          chunk_d    = chunk_at(in_ext, in_last_idx);
          first_d    = 1'b1;
          last_d     = (in_last_idx == '0);
          state_d    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            chunk_d = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            // Chunks leave most-significant first, so position counts down as index counts up.
            idx_d   = idx_q + 1'b1;
            chunk_d = chunk_at(ext_q, last_idx_q - idx_d);
            first_d = 1'b0;
            last_d  = (idx_d == last_idx_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ext_q      <= '0;
      last_idx_q <= '0;
      idx_q      <= '0;
      chunk_q    <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ext_q      <= ext_d;
      last_idx_q <= last_idx_d;
      idx_q      <= idx_d;
      chunk_q    <= chunk_d;
      first_q    <= first_d;
      last_q     <= last_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_EMIT);
  assign out_chunk = chunk_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign out_index = idx_q;
endmodule

// File: tb/tb_const_splitter.sv
// Bench for const_splitter: directed test-plan values, stall and reset scenarios, and a
// randomized sweep against an arithmetic reference model.
module tb_const_splitter;
  import const_splitter_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [DATA_BUS_WIDTH-1:0]  in_value = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [IMMEDIATE_WIDTH-1:0] out_chunk;
  logic                       out_first;
  logic                       out_last;
  logic [CHUNK_IDX_WIDTH-1:0] out_index;

  const_splitter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chunk (out_chunk),
    .out_first (out_first),
    .out_last  (out_last),
    .out_index (out_index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] obs_chunk[$];
  bit         obs_first[$];
  bit         obs_last[$];
  int         obs_idx[$];
  int         unstable;
  bit         timed_out;
  bit         lat_ok;
  bit         ready_after;

  // Reference: smallest n whose signed n*6-bit range holds the value.
  function automatic int ref_n(input logic [15:0] v);
    int sv;
    sv = int'($signed(v));
    for (int n = 1; n <= 3; n++) begin
      if (sv >= -(1 << (n*6-1)) && sv < (1 << (n*6-1))) return n;
    end
    return 3;
  endfunction

  function automatic logic [5:0] ref_chunk(input logic [15:0] v, input int n, input int k);
    int e;
    e = int'($signed(v)) & 32'h3FFFF;
    return 6'((e >> ((n - 1 - k) * 6)) & 63);
  endfunction

  // Offers v, then drains every chunk. mode 0: no stall, 1: 3-cycle stall per chunk with
  // in_valid pulses during EMIT, 2: random stall per chunk. Called at a negedge.
  task automatic run_value(input logic [15:0] v, input int mode);
    int guard;
    bit done;
    int stall;
    logic [8+CHUNK_IDX_WIDTH-1:0] snap;
    obs_chunk.delete(); obs_first.delete(); obs_last.delete(); obs_idx.delete();
    unstable = 0; timed_out = 0; done = 0; lat_ok = 0; ready_after = 0;
    in_value = v;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      timed_out = 1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_value = 16'($urandom);
    lat_ok = out_valid;
    guard = 0;
    while (!done && guard < 80) begin
      if (!out_valid) begin
        unstable++;
        @(negedge clk);
        guard++;
        continue;
      end
      stall = (mode == 1) ? 3 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      snap = {out_chunk, out_first, out_last, out_index};
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        if (mode == 1) begin
          in_valid = 1'b1;
          in_value = 16'($urandom);
        end
        @(negedge clk);
        guard++;
        if (!out_valid || {out_chunk, out_first, out_last, out_index} !== snap) unstable++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      obs_chunk.push_back(out_chunk);
      obs_first.push_back(out_first);
      obs_last.push_back(out_last);
      obs_idx.push_back(int'(out_index));
      @(posedge clk);
      @(negedge clk);
      guard++;
      out_ready = 1'b0;
      if (obs_last[$]) begin
        done = 1;
        ready_after = in_ready;
      end
    end
    if (!done) timed_out = 1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    n_cmp++;
    if ({in_ready, out_valid, out_first, out_last, out_chunk, out_index} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 6'h00, {CHUNK_IDX_WIDTH{1'b0}}}) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b first=%b last=%b chunk=%h idx=%0d, want 1 0 0 0 00 0",
               in_ready, out_valid, out_first, out_last, out_chunk, out_index);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] dv[5];
    int          dn[5];
    logic [5:0]  dc[5][3];
    dv[0] = 16'h0005; dn[0] = 1; dc[0][0] = 6'h05; dc[0][1] = 6'h00; dc[0][2] = 6'h00;
    dv[1] = 16'hFFE0; dn[1] = 1; dc[1][0] = 6'h20; dc[1][1] = 6'h00; dc[1][2] = 6'h00;
    dv[2] = 16'h0020; dn[2] = 2; dc[2][0] = 6'h00; dc[2][1] = 6'h20; dc[2][2] = 6'h00;
    dv[3] = 16'h1234; dn[3] = 3; dc[3][0] = 6'h01; dc[3][1] = 6'h08; dc[3][2] = 6'h34;
    dv[4] = 16'h8000; dn[4] = 3; dc[4][0] = 6'h38; dc[4][1] = 6'h00; dc[4][2] = 6'h00;
    for (int i = 0; i < 5; i++) begin
      run_value(dv[i], 0);
      n_cmp++;
      if (timed_out) begin
        n_bad++;
        $display("FAIL directed_timeout: value %h got timeout, want completion", dv[i]);
        continue;
      end
      n_cmp++;
      if (!lat_ok) begin
        n_bad++;
        $display("FAIL directed_latency: value %h out_valid got 0 cycle after accept, want 1", dv[i]);
      end
      n_cmp++;
      if (obs_chunk.size() != dn[i]) begin
        n_bad++;
        $display("FAIL directed_count: value %h got %0d chunks, want %0d", dv[i], obs_chunk.size(), dn[i]);
      end
      for (int k = 0; k < obs_chunk.size() && k < dn[i]; k++) begin
        n_cmp++;
        if ({obs_chunk[k], obs_first[k], obs_last[k]} !== {dc[i][k], k == 0, k == dn[i] - 1} ||
            obs_idx[k] != k) begin
          n_bad++;
          $display("FAIL directed_chunk: value %h k=%0d got chunk=%h f=%b l=%b idx=%0d, want chunk=%h f=%b l=%b idx=%0d",
                   dv[i], k, obs_chunk[k], obs_first[k], obs_last[k], obs_idx[k],
                   dc[i][k], k == 0, k == dn[i] - 1, k);
        end
      end
      n_cmp++;
      if (!ready_after) begin
        n_bad++;
        $display("FAIL directed_bubble: value %h in_ready got 0 cycle after last handshake, want 1", dv[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] exp_c[3];
    exp_c[0] = 6'h01; exp_c[1] = 6'h08; exp_c[2] = 6'h34;
    run_value(16'h1234, 1);
    n_cmp++;
    if (timed_out || unstable != 0) begin
      n_bad++;
      $display("FAIL stall_stable: got timeout=%b unstable=%0d, want 0 0", timed_out, unstable);
    end
    n_cmp++;
    if (obs_chunk.size() != 3) begin
      n_bad++;
      $display("FAIL stall_count: got %0d chunks, want 3", obs_chunk.size());
    end
    for (int k = 0; k < obs_chunk.size() && k < 3; k++) begin
      n_cmp++;
      if (obs_chunk[k] !== exp_c[k] || obs_idx[k] != k) begin
        n_bad++;
        $display("FAIL stall_chunk: k=%0d got %h idx=%0d, want %h idx=%0d", k, obs_chunk[k], obs_idx[k], exp_c[k], k);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_no_capture: out_valid got %b after sequence, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_emit();
    int guard;
    int extra;
    in_value = 16'h1234;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (!out_valid || out_chunk !== 6'h08 || out_index !== CHUNK_IDX_WIDTH'(1)) begin
      n_bad++;
      $display("FAIL midreset_pre: got vld=%b chunk=%h idx=%0d, want 1 08 1", out_valid, out_chunk, out_index);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_first, out_last, out_chunk, out_index} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 6'h00, {CHUNK_IDX_WIDTH{1'b0}}}) begin
      n_bad++;
      $display("FAIL midreset_async: got rdy=%b vld=%b first=%b last=%b chunk=%h idx=%0d, want 1 0 0 0 00 0",
               in_ready, out_valid, out_first, out_last, out_chunk, out_index);
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL midreset_drain: got %0d cycles of out_valid after reset, want 0", extra);
    end
    run_value(16'h0005, 0);
    n_cmp++;
    if (timed_out || obs_chunk.size() != 1 || obs_chunk[0] !== 6'h05 || !obs_first[0] || !obs_last[0]) begin
      n_bad++;
      $display("FAIL midreset_next: got timeout=%b count=%0d chunk=%h, want 0 1 05",
               timed_out, obs_chunk.size(), (obs_chunk.size() > 0) ? obs_chunk[0] : 6'h00);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] edges[14];
    logic [15:0] v;
    int          n;
    int          acc;
    edges = '{16'h0000, 16'h0001, 16'hFFFF, 16'h001F, 16'h0020, 16'hFFE0, 16'hFFDF,
              16'h07FF, 16'h0800, 16'hF800, 16'hF7FF, 16'h7FFF, 16'h8000, 16'h8001};
    for (int t = 0; t < 3014; t++) begin
      v = (t < 14) ? edges[t] : 16'($urandom);
      n = ref_n(v);
      run_value(v, 2);
      n_cmp++;
      if (timed_out || unstable != 0) begin
        n_bad++;
        $display("FAIL sweep_flow: value %h got timeout=%b unstable=%0d, want 0 0", v, timed_out, unstable);
        continue;
      end
      n_cmp++;
      if (obs_chunk.size() != n) begin
        n_bad++;
        $display("FAIL sweep_count: value %h got %0d chunks, want %0d", v, obs_chunk.size(), n);
        continue;
      end
      for (int k = 0; k < n; k++) begin
        n_cmp++;
        if (obs_chunk[k] !== ref_chunk(v, n, k) || obs_first[k] != (k == 0) ||
            obs_last[k] != (k == n - 1) || obs_idx[k] != k) begin
          n_bad++;
          $display("FAIL sweep_chunk: value %h k=%0d got %h f=%b l=%b idx=%0d, want %h f=%b l=%b idx=%0d",
                   v, k, obs_chunk[k], obs_first[k], obs_last[k], obs_idx[k],
                   ref_chunk(v, n, k), k == 0, k == n - 1, k);
        end
      end
      acc = int'($signed(obs_chunk[0]));
      for (int k = 1; k < n; k++) acc = (acc << 6) | int'(obs_chunk[k]);
      n_cmp++;
      if (16'(acc) !== v) begin
        n_bad++;
        $display("FAIL sweep_recon: got %h, want %h", 16'(acc), v);
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_emit();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
